// File: rtl/cache_read_arbiter.sv
// -----------------------------------------------------------------------------
// cache_read_arbiter
//
// Shares the single cache-refill read port of the AXI bridge among three
// requesters: I-cache refill (IC), D-cache refill (DC) and uncached load (UC).
// Priority is DC > UC > IC. An I-cache request that has been waiting for
// STARVE_LIMIT cycles or more is promoted to top priority. A read whose cache
// line matches an in-flight D-cache writeback is held back until the write
// completes, so a refill can never fetch a stale line.
//
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   {ic,dc,uc}_rvalid       read request, held until the matching rready
//   {ic,dc,uc}_raddr/rlen   request address / burst length-1
//   {ic,dc,uc}_rdata        returned line, valid only with rready
//   {ic,dc,uc}_rready       single-cycle completion pulse to the owner
//   m_rvalid/raddr/rlen     request towards the bridge (one at a time)
//   m_rdata, m_rready       line and completion pulse from the bridge
//   w_pending, w_addr       D-cache writeback in flight and its address
//   m_rsrc                  current grant: 0 none, 1 IC, 2 DC, 3 UC
// -----------------------------------------------------------------------------
module cache_read_arbiter #(
  parameter int STARVE_LIMIT = 16,
  parameter int LINE_BITS    = 6
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         ic_rvalid,
  input  logic [31:0]  ic_raddr,
  input  logic [7:0]   ic_rlen,
  output logic [511:0] ic_rdata,
  output logic         ic_rready,
  input  logic         dc_rvalid,
  input  logic [31:0]  dc_raddr,
  input  logic [7:0]   dc_rlen,
  output logic [511:0] dc_rdata,
  output logic         dc_rready,
  input  logic         uc_rvalid,
  input  logic [31:0]  uc_raddr,
  input  logic [7:0]   uc_rlen,
  output logic [511:0] uc_rdata,
  output logic         uc_rready,
  output logic         m_rvalid,
  output logic [31:0]  m_raddr,
  output logic [7:0]   m_rlen,
  input  logic [511:0] m_rdata,
  input  logic         m_rready,
  input  logic         w_pending,
  input  logic [31:0]  w_addr,
  output logic [1:0]   m_rsrc
);

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_IC     = 2'd1;
  localparam logic [1:0] SRC_DC     = 2'd2;
  localparam logic [1:0] SRC_UC     = 2'd3;
  localparam logic [7:0] STARVE_THR = 8'(STARVE_LIMIT);
  localparam logic [7:0] STARVE_MAX = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [31:0]  r_addr;
  logic [7:0]   r_len;
  logic [1:0]   r_src;
  logic         r_rvalid;
  logic [7:0]   r_starve_cnt;

  logic         w_ic_elig;
  logic         w_dc_elig;
  logic         w_uc_elig;
  logic [1:0]   w_win_src;
  logic [31:0]  w_win_addr;
  logic [7:0]   w_win_len;
  logic         w_grant;
  logic         w_complete;

  // Same cache line: only the tag bits above the line offset are compared.
  function automatic logic f_line_hit(input logic [31:0] a, input logic [31:0] b);
    return a[31:LINE_BITS] == b[31:LINE_BITS];
  endfunction

  assign w_ic_elig = ic_rvalid && !(w_pending && f_line_hit(ic_raddr, w_addr));
  assign w_dc_elig = dc_rvalid && !(w_pending && f_line_hit(dc_raddr, w_addr));
  assign w_uc_elig = uc_rvalid && !(w_pending && f_line_hit(uc_raddr, w_addr));

  // Arbitration: starving IC overrides DC > UC > IC.
  always_comb begin
    w_win_src = SRC_NONE;
    if (w_ic_elig && (r_starve_cnt >= STARVE_THR)) begin
      w_win_src = SRC_IC;
    end else if (w_dc_elig) begin
      w_win_src = SRC_DC;
    end else if (w_uc_elig) begin
      w_win_src = SRC_UC;
    end else if (w_ic_elig) begin
      w_win_src = SRC_IC;
    end else begin
      w_win_src = SRC_NONE;
    end
  end

  // Address/length of the arbitration winner.
  always_comb begin
    w_win_addr = 32'd0;
    w_win_len  = 8'd0;
    case (w_win_src)
      SRC_IC: begin
        w_win_addr = ic_raddr;
        w_win_len  = ic_rlen;
      end
      SRC_DC: begin
        w_win_addr = dc_raddr;
        w_win_len  = dc_rlen;
      end
      SRC_UC: begin
        w_win_addr = uc_raddr;
        w_win_len  = uc_rlen;
      end
      default: begin
        w_win_addr = 32'd0;
        w_win_len  = 8'd0;
      end
    endcase
  end

  // FSM next state: grant from IDLE, complete on bridge pulse in ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_src != SRC_NONE) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (m_rready) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant latch: request held stable towards the bridge until completion.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr   <= 32'd0;
      r_len    <= 8'd0;
      r_src    <= SRC_NONE;
      r_rvalid <= 1'b0;
    end else if (w_grant) begin
      r_addr   <= w_win_addr;
      r_len    <= w_win_len;
      r_src    <= w_win_src;
      r_rvalid <= 1'b1;
    end else if (w_complete) begin
      r_src    <= SRC_NONE;
      r_rvalid <= 1'b0;
    end
  end

  // I-cache wait counter, saturating; cleared while IC is idle or owns the port.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_starve_cnt <= 8'd0;
    end else if (!ic_rvalid) begin
      r_starve_cnt <= 8'd0;
    end else if ((w_grant && (w_win_src == SRC_IC)) || (r_src == SRC_IC)) begin
      r_starve_cnt <= 8'd0;
    end else if (r_starve_cnt != STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  assign m_rvalid = r_rvalid;
  assign m_raddr  = r_addr;
  assign m_rlen   = r_len;
  assign m_rsrc   = r_src;

  // Completion routing: bridge data and pulse go only to the granted owner.
  always_comb begin
    ic_rready = 1'b0;
    dc_rready = 1'b0;
    uc_rready = 1'b0;
    ic_rdata  = 512'd0;
    dc_rdata  = 512'd0;
    uc_rdata  = 512'd0;
    if (w_complete) begin
      case (r_src)
        SRC_IC: begin
          ic_rready = 1'b1;
          ic_rdata  = m_rdata;
        end
        SRC_DC: begin
          dc_rready = 1'b1;
          dc_rdata  = m_rdata;
        end
        SRC_UC: begin
          uc_rready = 1'b1;
          uc_rdata  = m_rdata;
        end
        default: begin
          ic_rready = 1'b0;
        end
      endcase
    end else begin
      ic_rready = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_read_arbiter
//
// Self-checking bench for cache_read_arbiter. Each scenario pushes the grants
// it expects (source, address, length) into a scoreboard queue; the bridge
// responder task pops one entry per observed grant and checks the grant, the
// stability of the request and the routing of the completion.
// -----------------------------------------------------------------------------
module tb_cache_read_arbiter;

  localparam int STARVE_LIMIT = 16;
  localparam int LINE_BITS    = 6;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         ic_rvalid, dc_rvalid, uc_rvalid;
  logic [31:0]  ic_raddr, dc_raddr, uc_raddr;
  logic [7:0]   ic_rlen, dc_rlen, uc_rlen;
  logic [511:0] ic_rdata, dc_rdata, uc_rdata;
  logic         ic_rready, dc_rready, uc_rready;
  logic         m_rvalid;
  logic [31:0]  m_raddr;
  logic [7:0]   m_rlen;
  logic [511:0] m_rdata;
  logic         m_rready;
  logic         w_pending;
  logic [31:0]  w_addr;
  logic [1:0]   m_rsrc;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   g_cyc    = 0;

  cache_read_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .LINE_BITS   (LINE_BITS)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .ic_rvalid(ic_rvalid),
    .ic_raddr (ic_raddr),
    .ic_rlen  (ic_rlen),
    .ic_rdata (ic_rdata),
    .ic_rready(ic_rready),
    .dc_rvalid(dc_rvalid),
    .dc_raddr (dc_raddr),
    .dc_rlen  (dc_rlen),
    .dc_rdata (dc_rdata),
    .dc_rready(dc_rready),
    .uc_rvalid(uc_rvalid),
    .uc_raddr (uc_raddr),
    .uc_rlen  (uc_rlen),
    .uc_rdata (uc_rdata),
    .uc_rready(uc_rready),
    .m_rvalid (m_rvalid),
    .m_raddr  (m_raddr),
    .m_rlen   (m_rlen),
    .m_rdata  (m_rdata),
    .m_rready (m_rready),
    .w_pending(w_pending),
    .w_addr   (w_addr),
    .m_rsrc   (m_rsrc)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_exp(input logic [1:0] src, input logic [31:0] addr, input logic [7:0] len);
    exp_t e;
    e.src  = src;
    e.addr = addr;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic set_rvalid(input logic [1:0] src, input logic v);
    case (src)
      2'd1:    ic_rvalid = v;
      2'd2:    dc_rvalid = v;
      2'd3:    uc_rvalid = v;
      default: ;
    endcase
  endtask

  // Bridge responder: waits for a grant, checks it against the scoreboard,
  // holds it for lat cycles, then completes with data and checks routing.
  task automatic serve(input int lat, input logic [511:0] data, input bit drop_mid, output int waited);
    exp_t e;
    waited = 0;
    do begin
      @(posedge aclk); #1;
      waited++;
    end while (!m_rvalid && waited < 40);
    n_checks++;
    if (!m_rvalid) begin
      n_fail++;
      $display("FAIL grant_timeout: m_rvalid=%0b required 1 after %0d cycles", m_rvalid, waited);
      return;
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_grant: src=%0d addr=%h, scoreboard empty", m_rsrc, m_raddr);
      return;
    end
    e = exp_q.pop_front();
    g_cyc = cyc;
    n_checks++;
    if (m_rsrc !== e.src) begin
      n_fail++;
      $display("FAIL grant_src: m_rsrc=%0d required %0d", m_rsrc, e.src);
    end
    n_checks++;
    if (m_raddr !== e.addr || m_rlen !== e.len) begin
      n_fail++;
      $display("FAIL grant_req: addr=%h len=%0d required addr=%h len=%0d", m_raddr, m_rlen, e.addr, e.len);
    end
    if (e.src == 2'd1) begin
      n_checks++;
      if (dut.r_starve_cnt !== 8'd0) begin
        n_fail++;
        $display("FAIL starve_clear: starve_cnt=%0d required 0", dut.r_starve_cnt);
      end
    end
    if (drop_mid) set_rvalid(e.src, 1'b0);
    for (int i = 1; i < lat; i++) begin
      @(posedge aclk); #1;
      n_checks++;
      if (m_rvalid !== 1'b1 || m_raddr !== e.addr || m_rsrc !== e.src) begin
        n_fail++;
        $display("FAIL issue_hold: rvalid=%0b addr=%h src=%0d required 1 %h %0d", m_rvalid, m_raddr, m_rsrc, e.addr, e.src);
      end
    end
    m_rdata  = data;
    m_rready = 1'b1;
    #1;
    n_checks++;
    if ({ic_rready, dc_rready, uc_rready} !== {e.src == 2'd1, e.src == 2'd2, e.src == 2'd3}) begin
      n_fail++;
      $display("FAIL rready_route: ic/dc/uc=%b%b%b required owner %0d only", ic_rready, dc_rready, uc_rready, e.src);
    end
    n_checks++;
    if (ic_rdata !== ((e.src == 2'd1) ? data : 512'd0) ||
        dc_rdata !== ((e.src == 2'd2) ? data : 512'd0) ||
        uc_rdata !== ((e.src == 2'd3) ? data : 512'd0)) begin
      n_fail++;
      $display("FAIL rdata_route: owner %0d ic=%h dc=%h uc=%h required %h", e.src, ic_rdata[31:0], dc_rdata[31:0], uc_rdata[31:0], data[31:0]);
    end
    @(posedge aclk); #1;
    m_rready = 1'b0;
    m_rdata  = 512'd0;
    set_rvalid(e.src, 1'b0);
    #1;
    n_checks++;
    if (m_rvalid !== 1'b0 || m_rsrc !== 2'd0 || {ic_rready, dc_rready, uc_rready} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_complete: rvalid=%0b src=%0d rready=%b required 0 0 000", m_rvalid, m_rsrc, {ic_rready, dc_rready, uc_rready});
    end
  endtask

  task automatic test_reset;
    aresetn   = 1'b0;
    ic_rvalid = 1'b1;
    dc_rvalid = 1'b0;
    uc_rvalid = 1'b0;
    ic_raddr  = 32'd0; dc_raddr = 32'd0; uc_raddr = 32'd0;
    ic_rlen   = 8'd0;  dc_rlen  = 8'd0;  uc_rlen  = 8'd0;
    m_rdata   = {16{32'hDEADBEEF}};
    m_rready  = 1'b1;
    w_pending = 1'b0;
    w_addr    = 32'd0;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if (m_rvalid !== 1'b0 || m_raddr !== 32'd0 || m_rlen !== 8'd0 || m_rsrc !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_master: rvalid=%0b addr=%h len=%0d src=%0d required all 0", m_rvalid, m_raddr, m_rlen, m_rsrc);
    end
    n_checks++;
    if ({ic_rready, dc_rready, uc_rready} !== 3'b000 || ic_rdata !== 512'd0 || dc_rdata !== 512'd0 || uc_rdata !== 512'd0) begin
      n_fail++;
      $display("FAIL reset_return: rready=%b required 000 and all rdata 0", {ic_rready, dc_rready, uc_rready});
    end
    n_checks++;
    if (dut.r_starve_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_starve: starve_cnt=%0d required 0", dut.r_starve_cnt);
    end
    ic_rvalid = 1'b0;
    aresetn   = 1'b1;
    // m_rready while idle must be ignored
    repeat (2) begin
      @(posedge aclk); #1;
      n_checks++;
      if (m_rvalid !== 1'b0 || {ic_rready, dc_rready, uc_rready} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_rready_ignored: rvalid=%0b rready=%b required 0 000", m_rvalid, {ic_rready, dc_rready, uc_rready});
      end
    end
    m_rready = 1'b0;
    m_rdata  = 512'd0;
  endtask

  task automatic test_single_ic;
    int w;
    ic_raddr  = 32'h1C000040;
    ic_rlen   = 8'd15;
    ic_rvalid = 1'b1;
    push_exp(2'd1, 32'h1C000040, 8'd15);
    serve(2, {16{32'hA5A5A5A5}}, 1'b0, w);
    n_checks++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL ic_latency: grant after %0d cycles required 1", w);
    end
  endtask

  task automatic test_priority;
    int w;
    dc_raddr = 32'h00001000; dc_rlen = 8'd7;
    uc_raddr = 32'h40000000; uc_rlen = 8'd0;
    ic_raddr = 32'h1C000080; ic_rlen = 8'd15;
    dc_rvalid = 1'b1; uc_rvalid = 1'b1; ic_rvalid = 1'b1;
    push_exp(2'd2, 32'h00001000, 8'd7);
    push_exp(2'd3, 32'h40000000, 8'd0);
    push_exp(2'd1, 32'h1C000080, 8'd15);
    serve(1, rand_line(), 1'b0, w);
    serve(2, rand_line(), 1'b0, w);
    n_checks++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL back_to_back_gap: next grant after %0d cycles required 1", w);
    end
    serve(3, rand_line(), 1'b0, w);
  endtask

  task automatic test_starvation;
    int w;
    int c0;
    int k_exp;
    k_exp = ((STARVE_LIMIT + 3) / 4) * 4;
    dc_raddr = 32'h00008000; dc_rlen = 8'd7;
    ic_raddr = 32'h1C000100; ic_rlen = 8'd15;
    dc_rvalid = 1'b1;
    ic_rvalid = 1'b1;
    c0 = cyc;
    for (int i = 0; i < k_exp / 4; i++) push_exp(2'd2, 32'h00008000, 8'd7);
    push_exp(2'd1, 32'h1C000100, 8'd15);
    for (int i = 0; i < k_exp / 4; i++) begin
      serve(3, rand_line(), 1'b0, w);
      dc_rvalid = 1'b1;
    end
    serve(1, rand_line(), 1'b0, w);
    dc_rvalid = 1'b0;
    n_checks++;
    if (g_cyc !== c0 + 1 + k_exp) begin
      n_fail++;
      $display("FAIL starve_grant_cycle: IC granted at cycle %0d required %0d", g_cyc - c0 - 1, k_exp);
    end
  endtask

  task automatic test_hazard;
    int w;
    w_pending = 1'b1;
    w_addr    = 32'h00002004;
    dc_raddr  = 32'h00002030; dc_rlen = 8'd7;
    uc_raddr  = 32'h00003000; uc_rlen = 8'd1;
    ic_raddr  = 32'h00002040; ic_rlen = 8'd15;
    dc_rvalid = 1'b1; uc_rvalid = 1'b1; ic_rvalid = 1'b1;
    push_exp(2'd3, 32'h00003000, 8'd1);
    push_exp(2'd1, 32'h00002040, 8'd15);
    serve(2, rand_line(), 1'b0, w);
    serve(1, rand_line(), 1'b0, w);
    repeat (4) begin
      @(posedge aclk); #1;
      n_checks++;
      if (m_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL hazard_hold: m_rvalid=%0b src=%0d required 0 while writeback pending", m_rvalid, m_rsrc);
      end
    end
    w_pending = 1'b0;
    push_exp(2'd2, 32'h00002030, 8'd7);
    serve(2, rand_line(), 1'b0, w);
    n_checks++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL hazard_release: grant after %0d cycles required 1", w);
    end
  endtask

  task automatic test_reset_mid_issue;
    int w;
    uc_raddr  = 32'h00006000;
    uc_rlen   = 8'd3;
    uc_rvalid = 1'b1;
    w = 0;
    do begin
      @(posedge aclk); #1;
      w++;
    end while (!m_rvalid && w < 40);
    n_checks++;
    if (m_rvalid !== 1'b1 || m_rsrc !== 2'd3) begin
      n_fail++;
      $display("FAIL mid_reset_grant: rvalid=%0b src=%0d required 1 3", m_rvalid, m_rsrc);
    end
    m_rdata  = {16{32'h5A5A5A5A}};
    m_rready = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (m_rvalid !== 1'b0 || m_raddr !== 32'd0 || m_rlen !== 8'd0 || m_rsrc !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset_out: rvalid=%0b addr=%h len=%0d src=%0d required all 0", m_rvalid, m_raddr, m_rlen, m_rsrc);
    end
    n_checks++;
    if (uc_rready !== 1'b0 || uc_rdata !== 512'd0) begin
      n_fail++;
      $display("FAIL async_reset_pulse: uc_rready=%0b required 0", uc_rready);
    end
    @(posedge aclk); #1;
    n_checks++;
    if ({ic_rready, dc_rready, uc_rready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_no_pulse: rready=%b required 000", {ic_rready, dc_rready, uc_rready});
    end
    m_rready = 1'b0;
    m_rdata  = 512'd0;
    #1;
    aresetn = 1'b1;
    push_exp(2'd3, 32'h00006000, 8'd3);
    serve(2, rand_line(), 1'b0, w);
    n_checks++;
    if (w !== 1) begin
      n_fail++;
      $display("FAIL regrant_after_reset: grant after %0d cycles required 1", w);
    end
  endtask

  task automatic test_drop_rvalid;
    int w;
    uc_raddr  = 32'h00005000;
    uc_rlen   = 8'd1;
    uc_rvalid = 1'b1;
    push_exp(2'd3, 32'h00005000, 8'd1);
    serve(3, rand_line(), 1'b1, w);
  endtask

  initial begin
    test_reset();
    test_single_ic();
    test_priority();
    test_starvation();
    test_hazard();
    test_reset_mid_issue();
    test_drop_rvalid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d grants outstanding required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
